// File: rtl/load_store_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit_if
// Description : Bundles the execute-stage request/response handshake and the
//               data-memory handshake of the load/store unit.
//               master : view of the load/store unit itself. It accepts core
//                        requests, returns responses and drives the memory
//                        request.
//               slave  : view of the surrounding core and memory. It drives
//                        requests, memory acks and read data.
//               Signals:
//                 req_*  : request from execute
//                          (valid/ready, is_store, funct3, addr, wdata, rd)
//                 resp_* : one-cycle completion (valid, rdata, rd, error)
//                 stall  : core hold
//                 mem_*  : memory handshake
//                          (req, we, addr, wdata, be, ack, rdata)
// Revision    : 1.0 - initial release
// ============================================================================
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;

    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [4:0]  resp_rd;
    logic        resp_error;
    logic        stall;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        input  req_valid, req_is_store, req_funct3, req_addr, req_wdata, req_rd,
        output req_ready,
        output resp_valid, resp_rdata, resp_rd, resp_error, stall,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_ack, mem_rdata
    );

    modport slave (
        output req_valid, req_is_store, req_funct3, req_addr, req_wdata, req_rd,
        input  req_ready,
        input  resp_valid, resp_rdata, resp_rd, resp_error, stall,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_ack, mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : Multi-cycle load/store unit between the execute stage and a
//               handshaked data memory.
//               - Supports byte, halfword and word access.
//               - Generates byte enables and replicates store data across
//                 the byte lanes.
//               - Sign/zero-extends load data.
//               - Flags misaligned accesses and illegal funct3 values.
//               - Aborts an access that is not acknowledged within
//                 TIMEOUT_CYCLES.
// Ports       : clk, reset : clock and synchronous active-high reset
//               bus        : load_store_unit_if.master (request/response +
//                            memory handshake, stall)
// Parameters  : TIMEOUT_CYCLES : ACCESS cycles without mem_ack before abort
//                                (1..255)
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic                    clk,
    input  logic                    reset,
    load_store_unit_if.master       bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    // The counter holds the number of completed ACCESS cycles. The last
    // allowed cycle is therefore the one where it equals TIMEOUT_CYCLES-1.
    localparam logic [7:0] c_timeout_last = 8'(TIMEOUT_CYCLES - 1);

    state_t      r_state;
    state_t      w_state_next;

    logic        r_is_store;
    logic [2:0]  r_funct3;
    logic [1:0]  r_offset;
    logic [4:0]  r_rd;
    logic [7:0]  r_count;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic [3:0]  r_mem_be;
    logic [31:0] r_resp_rdata;
    logic [4:0]  r_resp_rd;
    logic        r_resp_error;

    logic        w_legal;
    logic        w_misaligned;
    logic        w_req_err;
    logic [31:0] w_lane_wdata;
    logic [3:0]  w_lane_be;
    logic        w_timeout;
    logic [31:0] w_shifted;
    logic [31:0] w_load_data;

    // ------------------------------------------------------------------
    // Request decode (only meaningful while IDLE)
    // ------------------------------------------------------------------
    always_comb begin
        w_legal      = 1'b0;
        w_misaligned = 1'b0;
        w_lane_wdata = bus.req_wdata;
        w_lane_be    = 4'b1111;
        case (bus.req_funct3)
            3'b000: w_legal = 1'b1;
            3'b001: w_legal = 1'b1;
            3'b010: w_legal = 1'b1;
            3'b100: w_legal = !bus.req_is_store;
            3'b101: w_legal = !bus.req_is_store;
            default: w_legal = 1'b0;
        endcase
        // funct3[1:0] selects the size for both signed and unsigned loads.
        if (bus.req_funct3[1:0] == 2'b01)
            w_misaligned = bus.req_addr[0];
        else if (bus.req_funct3[1:0] == 2'b10)
            w_misaligned = (bus.req_addr[1:0] != 2'b00);
        if (bus.req_is_store) begin
            case (bus.req_funct3[1:0])
                2'b00: begin
                    w_lane_wdata = {4{bus.req_wdata[7:0]}};
                    w_lane_be    = 4'b0001 << bus.req_addr[1:0];
                end
                2'b01: begin
                    w_lane_wdata = {2{bus.req_wdata[15:0]}};
                    w_lane_be    = 4'b0011 << bus.req_addr[1:0];
                end
                default: begin
                    w_lane_wdata = bus.req_wdata;
                    w_lane_be    = 4'b1111;
                end
            endcase
        end
    end

    assign w_req_err = !w_legal || w_misaligned;
    assign w_timeout = (r_count == c_timeout_last);

    // ------------------------------------------------------------------
    // Load extraction: bring the addressed lane down to bit 0, then extend
    // ------------------------------------------------------------------
    assign w_shifted = bus.mem_rdata >> {r_offset, 3'b000};

    always_comb begin
        case (r_funct3)
            3'b000:  w_load_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
            3'b001:  w_load_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
            3'b100:  w_load_data = {24'd0, w_shifted[7:0]};
            3'b101:  w_load_data = {16'd0, w_shifted[15:0]};
            default: w_load_data = w_shifted;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_next;
    end

    // ------------------------------------------------------------------
    // FSM: next state and state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next   = r_state;
        bus.req_ready  = 1'b0;
        bus.stall      = 1'b0;
        bus.mem_req    = 1'b0;
        bus.mem_we     = 1'b0;
        bus.resp_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                bus.req_ready = 1'b1;
                bus.stall     = bus.req_valid;
                if (bus.req_valid)
                    w_state_next = w_req_err ? ST_RESP : ST_ACCESS;
            end
            ST_ACCESS: begin
                bus.stall   = 1'b1;
                bus.mem_req = 1'b1;
                bus.mem_we  = r_is_store;
                if (bus.mem_ack || w_timeout)
                    w_state_next = ST_RESP;
            end
            ST_RESP: begin
                bus.resp_valid = 1'b1;
                w_state_next   = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_is_store   <= 1'b0;
            r_funct3     <= 3'd0;
            r_offset     <= 2'd0;
            r_rd         <= 5'd0;
            r_count      <= 8'd0;
            r_mem_addr   <= 32'd0;
            r_mem_wdata  <= 32'd0;
            r_mem_be     <= 4'd0;
            r_resp_rdata <= 32'd0;
            r_resp_rd    <= 5'd0;
            r_resp_error <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        r_is_store <= bus.req_is_store;
                        r_funct3   <= bus.req_funct3;
                        r_offset   <= bus.req_addr[1:0];
                        r_rd       <= bus.req_rd;
                        r_count    <= 8'd0;
                        if (w_req_err) begin
                            // Rejected without touching memory: the
                            // response is ready on the next cycle.
                            r_resp_error <= 1'b1;
                            r_resp_rdata <= 32'd0;
                            r_resp_rd    <= bus.req_rd;
                        end else begin
                            r_mem_addr  <= {bus.req_addr[31:2], 2'b00};
                            r_mem_wdata <= w_lane_wdata;
                            r_mem_be    <= w_lane_be;
                        end
                    end
                end
                ST_ACCESS: begin
                    r_count <= r_count + 8'd1;
                    // An ack in the final allowed cycle takes priority over
                    // the timeout.
                    if (bus.mem_ack) begin
                        r_resp_error <= 1'b0;
                        r_resp_rdata <= r_is_store ? 32'd0 : w_load_data;
                        r_resp_rd    <= r_rd;
                    end else if (w_timeout) begin
                        r_resp_error <= 1'b1;
                        r_resp_rdata <= 32'd0;
                        r_resp_rd    <= r_rd;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_wdata  = r_mem_wdata;
    assign bus.mem_be     = r_mem_be;
    assign bus.resp_rdata = r_resp_rdata;
    assign bus.resp_rd    = r_resp_rd;
    assign bus.resp_error = r_resp_error;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_store_unit
// Description : Self-checking bench for load_store_unit.
//               - Applies a table of directed vectors with hand-computed
//                 expectations.
//               - Runs a reset-during-access sequence.
//               - Runs randomized transactions checked against a
//                 behavioural model of the access rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

    localparam int TIMEOUT = 15;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    load_store_unit_if bus();

    load_store_unit #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit        st;
        bit [2:0]  f3;
        bit [31:0] addr;
        bit [31:0] wdata;
        bit [4:0]  rd;
        bit [31:0] mrdata;
        int        k;          // ack in cycle T+k; 0 = never
        bit        exp_err;
        bit [31:0] exp_rdata;
        bit [3:0]  exp_be;
        bit [31:0] exp_wdata;
    } vec_t;

    typedef struct {
        bit        fault;      // rejected before any memory access
        bit        err;
        bit [31:0] rdata;
        bit [3:0]  be;
        bit [31:0] wdata;
    } exp_t;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference behaviour derived from the access rules with plain arithmetic.
    function automatic exp_t model(input bit st, input bit [2:0] f3,
                                   input bit [31:0] addr, input bit [31:0] wd,
                                   input bit [31:0] rdat, input int k);
        exp_t            e;
        int              size;
        int              off;
        bit              legal;
        longint unsigned m;
        longint unsigned v;
        off   = int'(addr % 4);
        legal = st ? (f3 <= 3'd2)
                   : (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 ||
                      f3 == 3'd4 || f3 == 3'd5);
        size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        e.fault = !legal || ((off % size) != 0);
        e.err   = e.fault || !(k >= 1 && k <= TIMEOUT);
        e.be    = st ? 4'(((1 << size) - 1) << off) : 4'hF;
        if (size == 1)
            e.wdata = 32'(wd[7:0]) * 32'h0101_0101;
        else if (size == 2)
            e.wdata = 32'(wd[15:0]) * 32'h0001_0001;
        else
            e.wdata = wd;
        m = (64'd1 << (8 * size)) - 64'd1;
        v = (64'(rdat) >> (8 * off)) & m;
        if (!f3[2] && size < 4 && v >= (m + 64'd1) / 64'd2)
            v = v | ~m;
        e.rdata = (e.err || st) ? 32'd0 : v[31:0];
        return e;
    endfunction

    // Drives one request and follows it through to the response.
    task automatic run_txn(input vec_t v, input string tag);
        exp_t        m;
        int          mreq_cycles = 0;
        int          lat         = 0;
        int          exp_lat;
        int          exp_mreq;
        bit          got         = 1'b0;
        bit          seen        = 1'b0;
        bit          held_ok     = 1'b1;
        bit          stall_ok    = 1'b1;
        logic [31:0] a0  = '0;
        logic [31:0] w0  = '0;
        logic [3:0]  be0 = '0;
        logic        we0 = 1'b0;
        logic [31:0] r_data = '0;
        logic [4:0]  r_rd   = '0;
        logic        r_err  = 1'b0;

        m = model(v.st, v.f3, v.addr, v.wdata, v.mrdata, v.k);
        @(negedge clk);
        check({tag, " req_ready"}, 32'(bus.req_ready), 32'd1);
        bus.req_valid    = 1'b1;
        bus.req_is_store = v.st;
        bus.req_funct3   = v.f3;
        bus.req_addr     = v.addr;
        bus.req_wdata    = v.wdata;
        bus.req_rd       = v.rd;
        #1;
        check({tag, " stall_at_T"}, 32'(bus.stall), 32'd1);
        @(negedge clk);
        // Request fields must be ignored after acceptance.
        bus.req_valid    = 1'b0;
        bus.req_is_store = 1'($urandom);
        bus.req_funct3   = 3'($urandom);
        bus.req_addr     = $urandom;
        bus.req_wdata    = $urandom;
        bus.req_rd       = 5'($urandom);
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (bus.resp_valid) begin
                lat    = cyc;
                got    = 1'b1;
                r_data = bus.resp_rdata;
                r_rd   = bus.resp_rd;
                r_err  = bus.resp_error;
                if (bus.stall) stall_ok = 1'b0;
                break;
            end
            if (!bus.stall) stall_ok = 1'b0;
            if (bus.mem_req) begin
                if (!seen) begin
                    seen = 1'b1;
                    a0   = bus.mem_addr;
                    w0   = bus.mem_wdata;
                    be0  = bus.mem_be;
                    we0  = bus.mem_we;
                end else if (bus.mem_addr !== a0 || bus.mem_wdata !== w0 ||
                             bus.mem_be !== be0 || bus.mem_we !== we0) begin
                    held_ok = 1'b0;
                end
                mreq_cycles++;
            end
            bus.mem_ack   = (cyc == v.k);
            bus.mem_rdata = (cyc == v.k) ? v.mrdata : $urandom;
            @(negedge clk);
        end
        bus.mem_ack = 1'b0;

        exp_lat  = m.fault ? 1 : ((v.k >= 1 && v.k <= TIMEOUT) ? v.k + 1 : TIMEOUT + 1);
        exp_mreq = m.fault ? 0 : ((v.k >= 1 && v.k <= TIMEOUT) ? v.k : TIMEOUT);
        check({tag, " resp_seen"},    32'(got), 32'd1);
        check({tag, " latency"},      32'(lat), 32'(exp_lat));
        check({tag, " mem_req_cyc"},  32'(mreq_cycles), 32'(exp_mreq));
        check({tag, " resp_error"},   32'(r_err), 32'(v.exp_err));
        check({tag, " resp_rdata"},   r_data, v.exp_rdata);
        check({tag, " resp_rd"},      32'(r_rd), 32'(v.rd));
        check({tag, " stall"},        32'(stall_ok), 32'd1);
        if (!m.fault) begin
            check({tag, " mem_held"}, 32'(held_ok), 32'd1);
            check({tag, " mem_addr"}, a0, v.addr & 32'hFFFF_FFFC);
            check({tag, " mem_we"},   32'(we0), 32'(v.st));
            check({tag, " mem_be"},   32'(be0), 32'(v.exp_be));
            if (v.st)
                check({tag, " mem_wdata"}, w0, v.exp_wdata);
        end
    endtask

    vec_t vecs[14];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //           st  f3     addr          wdata         rd     mrdata        k   err rdata         be       wdata
        vecs[0]  = '{0, 3'd0, 32'h0000_1003, 32'h0,        5'd1,  32'h80FF_1234, 1,  0, 32'hFFFF_FF80, 4'hF,    32'h0};
        vecs[1]  = '{0, 3'd4, 32'h0000_1003, 32'h0,        5'd2,  32'h80FF_1234, 1,  0, 32'h0000_0080, 4'hF,    32'h0};
        vecs[2]  = '{1, 3'd1, 32'h0000_0012, 32'hDEAD_BEEF, 5'd3, 32'h5555_5555, 2,  0, 32'h0,         4'b1100, 32'hBEEF_BEEF};
        vecs[3]  = '{0, 3'd2, 32'h0000_0006, 32'h0,        5'd4,  32'h1111_1111, 1,  1, 32'h0,         4'hF,    32'h0};
        vecs[4]  = '{1, 3'd4, 32'h0000_0020, 32'h1234_5678, 5'd5, 32'h1111_1111, 1,  1, 32'h0,         4'hF,    32'h0};
        vecs[5]  = '{0, 3'd2, 32'h0000_0040, 32'h0,        5'd6,  32'h1234_5678, 4,  0, 32'h1234_5678, 4'hF,    32'h0};
        vecs[6]  = '{0, 3'd2, 32'h0000_0080, 32'h0,        5'd7,  32'h9999_9999, 0,  1, 32'h0,         4'hF,    32'h0};
        vecs[7]  = '{0, 3'd2, 32'h0000_0084, 32'h0,        5'd8,  32'hCAFE_F00D, 15, 0, 32'hCAFE_F00D, 4'hF,    32'h0};
        vecs[8]  = '{0, 3'd1, 32'h0000_0202, 32'h0,        5'd9,  32'h8001_7FFF, 3,  0, 32'hFFFF_8001, 4'hF,    32'h0};
        vecs[9]  = '{0, 3'd5, 32'h0000_0202, 32'h0,        5'd10, 32'h8001_7FFF, 3,  0, 32'h0000_8001, 4'hF,    32'h0};
        vecs[10] = '{1, 3'd0, 32'h0000_0031, 32'h0000_00A5, 5'd11, 32'h0,        1,  0, 32'h0,         4'b0010, 32'hA5A5_A5A5};
        vecs[11] = '{0, 3'd1, 32'h0000_0005, 32'h0,        5'd12, 32'h0,         1,  1, 32'h0,         4'hF,    32'h0};
        vecs[12] = '{0, 3'd2, 32'h0000_0088, 32'h0,        5'd13, 32'h7777_7777, 16, 1, 32'h0,         4'hF,    32'h0};
        vecs[13] = '{1, 3'd2, 32'h0000_0100, 32'h1122_3344, 5'd0, 32'h0,         2,  0, 32'h0,         4'hF,    32'h1122_3344};

        bus.req_valid    = 1'b0;
        bus.req_is_store = 1'b0;
        bus.req_funct3   = 3'd0;
        bus.req_addr     = 32'd0;
        bus.req_wdata    = 32'd0;
        bus.req_rd       = 5'd0;
        bus.mem_ack      = 1'b0;
        bus.mem_rdata    = 32'd0;
        reset            = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst resp_error", 32'(bus.resp_error), 32'd0);
        check("rst resp_rdata", bus.resp_rdata, 32'd0);
        check("rst resp_rd",    32'(bus.resp_rd), 32'd0);
        check("rst mem_req",    32'(bus.mem_req), 32'd0);
        check("rst mem_we",     32'(bus.mem_we), 32'd0);
        check("rst mem_be",     32'(bus.mem_be), 32'd0);
        check("rst mem_addr",   bus.mem_addr, 32'd0);
        check("rst mem_wdata",  bus.mem_wdata, 32'd0);
        check("rst req_ready",  32'(bus.req_ready), 32'd1);
        check("rst stall",      32'(bus.stall), 32'd0);

        for (int i = 0; i < 14; i++)
            run_txn(vecs[i], $sformatf("vec%0d", i));

        // Reset in the middle of an access.
        @(negedge clk);                         // cycle T
        bus.req_valid    = 1'b1;
        bus.req_is_store = 1'b0;
        bus.req_funct3   = 3'd2;
        bus.req_addr     = 32'h0000_0040;
        bus.req_rd       = 5'd9;
        @(negedge clk);                         // T+1
        bus.req_valid = 1'b0;
        check("rstmid mem_req_T1", 32'(bus.mem_req), 32'd1);
        @(negedge clk);                         // T+2
        reset = 1'b1;
        @(negedge clk);                         // T+3
        reset         = 1'b0;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hABCD_EF01;
        check("rstmid mem_req_T3",    32'(bus.mem_req), 32'd0);
        check("rstmid resp_valid_T3", 32'(bus.resp_valid), 32'd0);
        @(negedge clk);                         // T+4
        bus.mem_ack = 1'b0;
        check("rstmid resp_valid_T4", 32'(bus.resp_valid), 32'd0);
        check("rstmid req_ready_T4",  32'(bus.req_ready), 32'd1);
        check("rstmid mem_req_T4",    32'(bus.mem_req), 32'd0);
        @(negedge clk);                         // T+5
        check("rstmid resp_valid_T5", 32'(bus.resp_valid), 32'd0);

        // Randomized transactions against the reference model.
        for (int n = 0; n < 150; n++) begin
            vec_t v;
            exp_t e;
            int   r;
            v.st     = 1'($urandom_range(0, 1));
            v.f3     = 3'($urandom_range(0, 7));
            v.addr   = $urandom;
            if ($urandom_range(0, 1) == 1) v.addr[1:0] = 2'b00;
            v.wdata  = $urandom;
            v.rd     = 5'($urandom);
            v.mrdata = $urandom;
            r        = int'($urandom_range(0, 9));
            v.k      = (r == 0) ? 0 : (r == 1) ? TIMEOUT : int'($urandom_range(1, 4));
            e = model(v.st, v.f3, v.addr, v.wdata, v.mrdata, v.k);
            v.exp_err   = e.err;
            v.exp_rdata = e.rdata;
            v.exp_be    = e.be;
            v.exp_wdata = e.wdata;
            run_txn(v, $sformatf("rnd%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle load/store unit between the CPU execute stage (ALU result as address, rs2 as store data) and a handshaked data memory. It replaces the single-cycle word-only memory path, adding byte/halfword access, byte enables, sign/zero extension, misalignment detection and a memory timeout. It stalls the core while a memory access is in flight.

## Interface
- TIMEOUT_CYCLES, 15: number of ACCESS cycles without mem_ack before the access is aborted with an error; range 1..255.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  reset, synchronous, active-high.
- req_valid  in  1  execute stage presents a load or store.
- req_ready  out  1  unit can accept a request; high only in IDLE.
- req_is_store  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3:
  - 000 B, 001 H, 010 W, 100 BU, 101 HU.
  - For stores, only 000, 001 and 010 are legal.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data (rs2).
- req_rd  in  5  load destination register.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_rd  out  5  rd captured at accept.
- resp_error  out  1  valid with resp_valid; set on misaligned access, illegal funct3, or timeout.
- stall  out  1  core must hold its PC and must not write back.
- mem_req  out  1  memory request.
- mem_we  out  1  write strobe, valid with mem_req.
- mem_addr  out  32  word address: {req_addr[31:2], 2'b00}.
- mem_wdata  out  32  lane-replicated store data.
- mem_be  out  4  byte enables.
- mem_ack  in  1  memory completion; sampled only in ACCESS.
- mem_rdata  in  32  read word; valid when mem_ack is high.

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch addr, funct3, is_store, wdata and rd.
  - Illegal or misaligned request → RESP with error=1, no memory access.
  - Otherwise → ACCESS, with the wait counter cleared.
  - Misaligned: H/HU with addr[0]=1; W with addr[1:0]≠00.
- ACCESS:
  - mem_req=1; all mem_* outputs are held constant.
  - The counter increments every cycle.
  - mem_ack=1 → capture mem_rdata, go to RESP with error=0.
  - Otherwise, when the counter reaches TIMEOUT_CYCLES → go to RESP with error=1 and resp_rdata=0.
  - If mem_ack arrives in the same cycle the counter reaches TIMEOUT_CYCLES, the ack wins.
- RESP: resp_valid=1 for exactly one cycle → IDLE. There is no response backpressure.
- Store lanes (o = addr[1:0]):
  - SB: mem_wdata={4{wdata[7:0]}}, mem_be=4'b0001<<o.
  - SH: mem_wdata={2{wdata[15:0]}}, mem_be=4'b0011<<o.
  - SW: mem_wdata=wdata, mem_be=4'b1111.
  - Loads: mem_be=4'b1111, mem_we=0.
- Load extraction:
  - s = mem_rdata >> (8·o).
  - B: sign-extend s[7:0]; BU: zero-extend s[7:0].
  - H: sign-extend s[15:0]; HU: zero-extend s[15:0].
  - W: s.
- Loads with rd=0 complete normally; suppressing the write is the register file's job.
- stall = (IDLE & req_valid) | ACCESS. stall is 0 in RESP, so the core advances and writes back in that cycle.

## Timing
- Reset, on the clock edge where reset=1:
  - State → IDLE, counter → 0.
  - resp_valid, resp_error, resp_rdata, resp_rd, mem_req, mem_we, mem_be, mem_addr and mem_wdata → 0.
  - req_ready=1 from the next cycle.
- Reset during ACCESS: the access is abandoned, mem_req=0 next cycle, and no resp_valid is produced.
- A late mem_ack while in IDLE or RESP is ignored.
- Latency, with the request accepted at cycle T:
  - ACCESS starts at T+1.
  - mem_ack at T+k (k≥1) → resp_valid at T+k+1.
  - Minimum total is 2 cycles after accept.
- Error paths:
  - Misaligned or illegal request: resp_valid at T+1.
  - Timeout: resp_valid at T+TIMEOUT_CYCLES+1.
- Back-to-back: a new request can be accepted in the cycle after RESP (IDLE). Throughput is at best one access per 3 cycles.
- req_* inputs are sampled only in IDLE; later changes have no effect.
- resp_rdata, resp_rd and resp_error hold their values until the next RESP or reset.

## Test plan
- LB at addr 0x1003, memory returns 0x80FF_1234 with ack at T+1 → resp_valid at T+2, resp_rdata=0xFFFF_FF80, error=0. LBU on the same data → 0x0000_0080.
- SH of wdata 0xDEAD_BEEF at 0x0012 → mem_addr=0x0010, mem_be=4'b1100, mem_wdata=0xBEEF_BEEF, mem_we=1; after ack, resp_rdata=0.
- LW at 0x0006 → no mem_req ever, resp_valid with error=1 at T+1. Store with funct3=100 → same behaviour.
- TIMEOUT_CYCLES=15 with mem_ack held low → mem_req high for exactly 15 cycles, then resp_valid and error=1. Variant: ack in the 15th cycle → success.
- LW at 0x0040 with ack at T+4 and stall checked each cycle → stall=1 from T to T+4, 0 at T+5 (resp_valid=1). Next request accepted at T+6.
- Reset asserted at T+2 mid-access → mem_req=0 at T+3, no resp_valid. An ack arriving at T+3 is ignored, and req_ready=1.
